framing_decoding: RTL

FRAMING_DECODING -- requirements
Module: framing_decoding

---
 rtl/framing_pkg.sv | 16 +
 rtl/crc16_serial.sv | 25 ++
 rtl/framing_decoding.sv | 139 +++++++++++++
 3 files changed

// File: rtl/framing_pkg.sv
// Shared constants and state encoding for the framing encoder/decoder pair.
package framing_pkg;
    localparam logic [8:0]  PN9_SEED = 9'h1FF;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'h0000;
    localparam logic [7:0]  MIN_LEN  = 8'd2;
    localparam logic [7:0]  MAX_LEN  = 8'd127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PHR,
        ST_PSDU,
        ST_CRC,
        ST_DONE
    } state_t;
endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 ITU-T engine, one data bit per enabled cycle.
module crc16_serial
    import framing_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        data,
    output logic [15:0] crc
);
    logic fb;

    assign fb = crc[15] ^ data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end
endmodule

// File: rtl/framing_decoding.sv
// De-whitens a PN9-whitened serial frame, emits PHR/payload bytes and checks CRC-16.
// state | meaning: IDLE wait frame, PHR length byte, PSDU payload, CRC 16 check bits, DONE wait in_valid low
module framing_decoding
    import framing_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       framing_decoding_in,
    input  logic       framing_decoding_in_valid,
    output logic [7:0] phr_psdu_out,
    output logic       phr_psdu_out_valid,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       frame_err
);
    state_t      state;
    logic [8:0]  lfsr;
    logic [8:0]  lfsr_next;
    logic [2:0]  bit_cnt;
    logic [6:0]  byte_cnt;
    logic [6:0]  byte_cnt_inc;
    logic [6:0]  payload_len;
    logic [6:0]  shift;
    logic [14:0] crc_rx;
    logic [15:0] crc_rx_full;
    logic [15:0] crc_calc;
    logic [7:0]  byte_next;
    logic        bit_d;
    logic        crc_en;
    logic        crc_clr;

    assign bit_d        = framing_decoding_in ^ lfsr[8];
    assign lfsr_next    = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    assign byte_next    = {bit_d, shift};
    assign crc_rx_full  = {bit_d, crc_rx};
    assign byte_cnt_inc = byte_cnt + 7'd1;
    assign crc_en       = (state == ST_PSDU) && framing_decoding_in_valid;
    assign crc_clr      = (state == ST_IDLE);

    crc16_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .enable (crc_en),
        .clear  (crc_clr),
        .data   (bit_d),
        .crc    (crc_calc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            lfsr               <= PN9_SEED;
            bit_cnt            <= 3'd0;
            byte_cnt           <= 7'd0;
            payload_len        <= 7'd0;
            shift              <= 7'd0;
            crc_rx             <= 15'd0;
            phr_psdu_out       <= 8'd0;
            phr_psdu_out_valid <= 1'b0;
            frame_done         <= 1'b0;
            crc_ok             <= 1'b0;
            frame_err          <= 1'b0;
        end else begin
            phr_psdu_out_valid <= 1'b0;
            frame_done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 7'd0;
                    if (framing_decoding_in_valid) begin
                        shift   <= byte_next[7:1];
                        lfsr    <= lfsr_next;
                        bit_cnt <= 3'd1;
                        state   <= ST_PHR;
                    end else begin
                        lfsr <= PN9_SEED;
                    end
                end
                ST_PHR, ST_PSDU, ST_CRC: begin
                    if (!framing_decoding_in_valid) begin
                        // premature drop: partial byte is simply abandoned
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                        frame_err  <= 1'b1;
                        crc_ok     <= 1'b0;
                    end else begin
                        lfsr    <= lfsr_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= byte_next[7:1];
                        if (state == ST_CRC) begin
                            crc_rx <= crc_rx_full[15:1];
                        end
                        if (bit_cnt == 3'd7) begin
                            if (state == ST_PHR) begin
                                phr_psdu_out       <= byte_next;
                                phr_psdu_out_valid <= 1'b1;
                                byte_cnt           <= 7'd0;
                                if (byte_next < MIN_LEN || byte_next > MAX_LEN) begin
                                    state      <= ST_DONE;
                                    frame_done <= 1'b1;
                                    frame_err  <= 1'b1;
                                    crc_ok     <= 1'b0;
                                end else begin
                                    payload_len <= byte_next[6:0] - 7'd2;
                                    state       <= (byte_next == MIN_LEN) ? ST_CRC : ST_PSDU;
                                end
                            end else if (state == ST_PSDU) begin
                                phr_psdu_out       <= byte_next;
                                phr_psdu_out_valid <= 1'b1;
                                if (byte_cnt_inc == payload_len) begin
                                    byte_cnt <= 7'd0;
                                    state    <= ST_CRC;
                                end else begin
                                    byte_cnt <= byte_cnt_inc;
                                end
                            end else if (byte_cnt[0]) begin
                                state      <= ST_DONE;
                                frame_done <= 1'b1;
                                frame_err  <= 1'b0;
                                crc_ok     <= (crc_rx_full == crc_calc);
                            end else begin
                                byte_cnt <= 7'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    lfsr     <= PN9_SEED;
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 7'd0;
                    if (!framing_decoding_in_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
